read_operation: RTL

Read-side pointer and empty-flag controller for the asynchronous FIFO. Holds the binary read pointer, drives the storage read address, and publishes a Gray-coded read pointer for synchronisation into the write domain. Compares its next Gray pointer against the write pointer already synchronised into the read domain, and registers the empty flag. This block is the counterpart of the write-side pointer/full controller and sits between the read-domain synchroniser and the dual-port storage.

---
 rtl/async_fifo_pkg.sv | 31 +++
 rtl/read_operation_gray2bin_conv.sv | 29 ++
 rtl/read_operation.sv | 124 ++++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for both sides of the asynchronous FIFO.
//   - SIZE_DEFAULT     : default address width (depth = 2**SIZE_DEFAULT)
//   - AE_LEVEL_DEFAULT : default almost-empty threshold in words
//   - bin2gray()       : binary to reflected Gray code
//   - gray2bin()       : reflected Gray code to binary
// The functions work on 32-bit zero-extended values. Callers slice the result
// back to their pointer width. Zero extension does not change either mapping.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int SIZE_DEFAULT     = 4;
    localparam int AE_LEVEL_DEFAULT = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin     = '0;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/read_operation_gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Combinational Gray-to-binary converter. It uses an XOR prefix that runs
// from the MSB down to the LSB.
// Parameters:
//   W     : width of the code word
// Ports:
//   gray  : input  [W-1:0]  Gray-coded value
//   bin   : output [W-1:0]  equivalent binary value
// -----------------------------------------------------------------------------
module gray2bin_conv #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic [W-1:0] acc;

    always_comb begin
        acc        = '0;
        acc[W-1]   = gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ gray[i];
        end
        bin = acc;
    end

endmodule

// File: rtl/read_operation.sv
// -----------------------------------------------------------------------------
// read_operation
// Read-side pointer and empty-flag controller of the asynchronous FIFO.
// The block keeps the binary read pointer and drives the storage read address.
// It publishes a registered Gray read pointer for the write domain. It also
// registers the empty flag, computed from the next Gray pointer and the write
// pointer that has already been synchronised into rclk.
//
// Optional feature macro: RD_ALMOST_EMPTY_EN
//   When this macro is defined, the block adds a registered fill level
//   (rlevel) and an almost-empty flag (ralmost_empty, set when level <=
//   AE_LEVEL).
//
// Parameters:
//   SIZE      : address width, depth = 2**SIZE, pointers are SIZE+1 bits
//   AE_LEVEL  : almost-empty threshold in words (feature build only)
// Ports:
//   rclk          in   read-domain clock
//   rrst          in   synchronous active-high reset
//   rq2_wptr      in   [SIZE:0]   Gray write pointer, synchronised into rclk
//   rinc          in   read request, ignored while rempty=1
//   rempty        out  registered empty flag
//   raddr         out  [SIZE-1:0] storage read address
//   rptr          out  [SIZE:0]   registered Gray read pointer
//   ralmost_empty out  registered almost-empty flag (feature build only)
//   rlevel        out  [SIZE:0]   registered fill level (feature build only)
//
// Handshake: a read is accepted on a rising rclk edge when rinc=1 and
// rempty=0. rempty acts as the inverted "valid" signal and rinc acts as the
// "ready/take" signal. The pointer, raddr, rptr and rempty update together on
// that same edge.
// -----------------------------------------------------------------------------
module read_operation
    import async_fifo_pkg::*;
#(
    parameter int SIZE     = SIZE_DEFAULT,
    parameter int AE_LEVEL = AE_LEVEL_DEFAULT
) (
    input  logic            rclk,
    input  logic            rrst,
    input  logic [SIZE:0]   rq2_wptr,
    input  logic            rinc,
    output logic            rempty,
    output logic [SIZE-1:0] raddr,
`ifdef RD_ALMOST_EMPTY_EN
    output logic            ralmost_empty,
    output logic [SIZE:0]   rlevel,
`endif
    output logic [SIZE:0]   rptr
);

    logic [SIZE:0] rbin_q,   rbin_d;
    logic [SIZE:0] rptr_q,   rptr_d;
    logic          rempty_q, rempty_d;
    logic          rd_en;
    logic [31:0]   gray_wide;

    // A read is honoured only while the registered flag says data exists.
    // This keeps the pointer from ever passing the synchronised write pointer.
    assign rd_en = rinc & ~rempty_q;

    always_comb begin
        rbin_d    = rbin_q + {{SIZE{1'b0}}, rd_en};
        gray_wide = bin2gray(32'(rbin_d));
        rptr_d    = gray_wide[SIZE:0];
        // Empty when the next read pointer catches the write pointer exactly.
        // Both pointers are compared on all bits, including the lap MSB.
        rempty_d  = (rptr_d == rq2_wptr);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
        end
    end

    assign rempty = rempty_q;
    assign raddr  = rbin_q[SIZE-1:0];
    assign rptr   = rptr_q;

`ifdef RD_ALMOST_EMPTY_EN
    logic [SIZE:0] wbin_s;
    logic [SIZE:0] rlevel_q, rlevel_d;
    logic          rae_q,    rae_d;

    gray2bin_conv #(
        .W (SIZE + 1)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    always_comb begin
        // The subtraction wraps modulo 2**(SIZE+1). This gives the correct
        // occupancy across pointer laps.
        rlevel_d = wbin_s - rbin_d;
        rae_d    = (rlevel_d <= (SIZE+1)'(AE_LEVEL));
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel_q <= '0;
            rae_q    <= 1'b1;
        end else begin
            rlevel_q <= rlevel_d;
            rae_q    <= rae_d;
        end
    end

    assign rlevel        = rlevel_q;
    assign ralmost_empty = rae_q;
`else
    // The threshold has no effect without the level logic.
    logic ae_level_unused;
    assign ae_level_unused = ^AE_LEVEL;
`endif

endmodule
